// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller for an in-order pipeline.
// It tracks outstanding loads in a 32-bit busy mask and detects load-use and
// WAW hazards at decode. It arbitrates memory-wait freezes, branch flushes and
// use stalls, and raises a sticky timeout flag when memory waits for too long.
module hazard_stall_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_addr_decode,
   input  logic [4:0]  rs2_addr_decode,
   input  logic        rs1_used_decode,
   input  logic        rs2_used_decode,
   input  logic        valid_decode,
   input  logic [4:0]  rd_addr_decode,
   input  logic        rd_write_decode,
   input  logic        is_load_decode,
   input  logic        load_mem,
   input  logic [4:0]  rd_addr_mem,
   input  logic        mem_ready,
   input  logic        branch_taken_execute,
   output logic        stall_fetch,
   output logic        stall_decode,
   output logic        bubble_execute,
   output logic        flush_decode,
   output logic        stall_all,
   output logic [31:0] busy_mask,
   output logic        mem_timeout
);

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   logic [31:0] busy_q, busy_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;

   logic mem_wait;
   logic load_clear;
   logic rs1_haz, rs2_haz, waw_haz;
   logic use_stall;
   logic issue;

   // Classify the MEM-stage load: still waiting, or its data returns this cycle.
   // A returning load bypasses its own busy bit because WB forwards it next cycle.
   always_comb begin
      mem_wait   = load_mem & ~mem_ready;
      load_clear = load_mem & mem_ready & (rd_addr_mem != 5'd0);
      rs1_haz    = rs1_used_decode & busy_q[rs1_addr_decode]
                   & ~(load_clear & (rd_addr_mem == rs1_addr_decode));
      rs2_haz    = rs2_used_decode & busy_q[rs2_addr_decode]
                   & ~(load_clear & (rd_addr_mem == rs2_addr_decode));
      waw_haz    = valid_decode & is_load_decode & rd_write_decode
                   & busy_q[rd_addr_decode]
                   & ~(load_clear & (rd_addr_mem == rd_addr_decode));
      use_stall  = valid_decode & (rs1_haz | rs2_haz | waw_haz);
      issue      = valid_decode & ~mem_wait & ~branch_taken_execute & ~use_stall;
   end

   // Pipeline control: memory freeze beats branch flush, which beats use stall.
   always_comb begin
      stall_all      = mem_wait;
      stall_fetch    = 1'b0;
      stall_decode   = 1'b0;
      bubble_execute = 1'b0;
      flush_decode   = 1'b0;
      if (mem_wait) begin
         stall_fetch  = 1'b1;
         stall_decode = 1'b1;
      end else if (branch_taken_execute) begin
         flush_decode   = 1'b1;
         bubble_execute = 1'b1;
      end else if (use_stall) begin
         stall_fetch    = 1'b1;
         stall_decode   = 1'b1;
         bubble_execute = 1'b1;
      end
   end

   // Busy-mask next state: the returning load clears first, so an issuing load to
   // the same register re-sets it. x0 is never tracked.
   always_comb begin
      busy_d = busy_q;
      if (load_clear) begin
         busy_d[rd_addr_mem] = 1'b0;
      end
      if (issue & is_load_decode & rd_write_decode & (rd_addr_decode != 5'd0)) begin
         busy_d[rd_addr_decode] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Saturating run-length of memory-wait cycles, and a sticky flag set on reaching the limit.
   always_comb begin
      wait_cnt_d = 16'd0;
      if (mem_wait) begin
         wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
      end
      timeout_d = timeout_q | (mem_wait & (wait_cnt_d == TIMEOUT_W));
   end

   // State registers; reset discards every outstanding load immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= 32'd0;
         wait_cnt_q <= 16'd0;
         timeout_q  <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign busy_mask   = busy_q;
   assign mem_timeout = timeout_q;

endmodule
